// File: rtl/fft_pkg.sv
// Shared definitions for the radix-2 FFT butterfly: saturation bounds, FSM
// states, multiply-slot encodings and the symmetric 16-bit saturator.
package fft_pkg;

    localparam logic [15:0] SAT_MAX = 16'h7FFF;
    localparam logic [15:0] SAT_MIN = 16'h8001;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        WAIT    = 3'd2,
        COMBINE = 3'd3,
        OUTPUT  = 3'd4
    } state_t;

    // Order of the four real products that make up W*B.
    typedef enum logic [1:0] {
        MUL_RR = 2'd0,  // w_re * b_re
        MUL_II = 2'd1,  // w_im * b_im
        MUL_RI = 2'd2,  // w_re * b_im
        MUL_IR = 2'd3   // w_im * b_re
    } mul_idx_t;

    // Symmetric clamp to [-32767, 32767], same range as the multiplier output.
    function automatic logic [15:0] sat16(input logic signed [16:0] v);
        if (v > 17'sd32767)
            return SAT_MAX;
        else if (v < -17'sd32767)
            return SAT_MIN;
        else
            return v[15:0];
    endfunction

endpackage

// File: rtl/fixed_point_multiplier.sv
// Shared signed 16x16 fixed-point multiplier: one-cycle latency, rescales the
// product to EXP_WIDTH_PRODUCT fractional bits (floor) and saturates symmetrically.
module fixed_point_multiplier #(
    parameter int EXP_WIDTH_A       = 14,
    parameter int EXP_WIDTH_B       = 5,
    parameter int EXP_WIDTH_PRODUCT = 5
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic signed [15:0] a,
    input  logic signed [15:0] b,
    output logic signed [15:0] product,
    output logic               done
);

    localparam int SHIFT = EXP_WIDTH_A + EXP_WIDTH_B - EXP_WIDTH_PRODUCT;

    logic signed [31:0] full;
    logic signed [31:0] scaled;
    logic signed [15:0] sat;

    // NOTE: every variable assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        full   = 32'(a) * 32'(b);
        scaled = full >>> SHIFT;
        if (scaled > 32'sd32767)
            sat = 16'sh7FFF;
        else if (scaled < -32'sd32767)
            sat = -16'sd32767;
        else
            sat = scaled[15:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            product <= '0;
            done    <= 1'b0;
        end else begin
            done <= enable;
            if (enable)
                product <= sat;
        end
    end

endmodule

// File: rtl/fft_butterfly_r2.sv
// Radix-2 DIT butterfly: X = A + W*B, Y = A - W*B, with W*B built from four
// real multiplies time-multiplexed over one shared fixed_point_multiplier.
module fft_butterfly_r2
    import fft_pkg::*;
#(
    parameter int DATA_FRAC = 5,
    parameter int TW_FRAC   = 14,
    parameter bit SCALE     = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [15:0] a_re,
    input  logic signed [15:0] a_im,
    input  logic signed [15:0] b_re,
    input  logic signed [15:0] b_im,
    input  logic signed [15:0] w_re,
    input  logic signed [15:0] w_im,
    output logic               out_valid,
    input  logic               out_ready,
    output logic signed [15:0] x_re,
    output logic signed [15:0] x_im,
    output logic signed [15:0] y_re,
    output logic signed [15:0] y_im
);

    state_t             state;
    mul_idx_t           idx;
    logic               mul_en;
    logic               mul_done;
    logic signed [15:0] mul_a;
    logic signed [15:0] mul_b;
    logic signed [15:0] mul_product;

    logic signed [15:0] a_re_q, a_im_q, b_re_q, b_im_q, w_re_q, w_im_q;
    logic signed [15:0] p_q [4];

    logic signed [16:0] d_re, s_im;
    logic signed [15:0] t_re, t_im;
    logic signed [16:0] xs_re, xs_im, ys_re, ys_im;
    logic signed [15:0] xn_re, xn_im, yn_re, yn_im;

    fixed_point_multiplier #(
        .EXP_WIDTH_A      (TW_FRAC),
        .EXP_WIDTH_B      (DATA_FRAC),
        .EXP_WIDTH_PRODUCT(DATA_FRAC)
    ) u_mul (
        .clk    (clk),
        .rst_n  (rst_n),
        .enable (mul_en),
        .a      (mul_a),
        .b      (mul_b),
        .product(mul_product),
        .done   (mul_done)
    );

    always_comb begin
        mul_a = w_re_q;
        mul_b = b_re_q;
        case (idx)
            MUL_RR:  begin mul_a = w_re_q; mul_b = b_re_q; end
            MUL_II:  begin mul_a = w_im_q; mul_b = b_im_q; end
            MUL_RI:  begin mul_a = w_re_q; mul_b = b_im_q; end
            MUL_IR:  begin mul_a = w_im_q; mul_b = b_re_q; end
            default: ;
        endcase
    end

    // All sums are formed at 17 bits so nothing wraps before saturation/scaling.
    always_comb begin
        d_re  = 17'(p_q[0]) - 17'(p_q[1]);
        s_im  = 17'(p_q[2]) + 17'(p_q[3]);
        t_re  = sat16(d_re);
        t_im  = sat16(s_im);
        xs_re = 17'(a_re_q) + 17'(t_re);
        xs_im = 17'(a_im_q) + 17'(t_im);
        ys_re = 17'(a_re_q) - 17'(t_re);
        ys_im = 17'(a_im_q) - 17'(t_im);
        if (SCALE) begin
            xn_re = xs_re[16:1];
            xn_im = xs_im[16:1];
            yn_re = ys_re[16:1];
            yn_im = ys_im[16:1];
        end else begin
            xn_re = sat16(xs_re);
            xn_im = sat16(xs_im);
            yn_re = sat16(ys_re);
            yn_im = sat16(ys_im);
        end
    end

    // Enable is raised on the edge that enters ISSUE, so it is high for exactly the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= MUL_RR;
            mul_en    <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            x_re      <= '0;
            x_im      <= '0;
            y_re      <= '0;
            y_im      <= '0;
            a_re_q    <= '0;
            a_im_q    <= '0;
            b_re_q    <= '0;
            b_im_q    <= '0;
            w_re_q    <= '0;
            w_im_q    <= '0;
            for (int i = 0; i < 4; i++)
                p_q[i] <= '0;
        end else begin
            mul_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_re_q   <= a_re;
                        a_im_q   <= a_im;
                        b_re_q   <= b_re;
                        b_im_q   <= b_im;
                        w_re_q   <= w_re;
                        w_im_q   <= w_im;
                        in_ready <= 1'b0;
                        mul_en   <= 1'b1;
                        state    <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (mul_done) begin
                        p_q[idx] <= mul_product;
                        if (idx != MUL_IR) begin
                            idx    <= mul_idx_t'(idx + 2'd1);
                            mul_en <= 1'b1;
                            state  <= ISSUE;
                        end else begin
                            state <= COMBINE;
                        end
                    end
                end
                COMBINE: begin
                    x_re      <= xn_re;
                    x_im      <= xn_im;
                    y_re      <= yn_re;
                    y_im      <= yn_im;
                    out_valid <= 1'b1;
                    state     <= OUTPUT;
                end
                OUTPUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        idx       <= MUL_RR;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fft_butterfly_r2.sv
// Self-checking bench: two butterflies (SCALE=0 and SCALE=1) share stimulus and
// are compared against an integer-arithmetic model of the butterfly equations.
module tb_fft_butterfly_r2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
    logic        in_ready0, out_valid0, in_ready1, out_valid1;
    logic [15:0] x0_re, x0_im, y0_re, y0_im;
    logic [15:0] x1_re, x1_im, y1_re, y1_im;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    fft_butterfly_r2 #(.DATA_FRAC(5), .TW_FRAC(14), .SCALE(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid0), .out_ready(out_ready),
        .x_re(x0_re), .x_im(x0_im), .y_re(y0_re), .y_im(y0_im)
    );

    fft_butterfly_r2 #(.DATA_FRAC(5), .TW_FRAC(14), .SCALE(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im), .w_re(w_re), .w_im(w_im),
        .out_valid(out_valid1), .out_ready(out_ready),
        .x_re(x1_re), .x_im(x1_im), .y_re(y1_re), .y_im(y1_im)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int s16(input logic [15:0] v);
        return int'($signed(v));
    endfunction

    function automatic int clamp(input int v);
        if (v > 32767)  return 32767;
        if (v < -32767) return -32767;
        return v;
    endfunction

    // Q1.14 * Q10.5 -> Q10.5, rounding toward minus infinity, then clamped.
    function automatic int cmul(input int w, input int b);
        return clamp((w * b) >>> 14);
    endfunction

    function automatic logic [63:0] model(input logic [15:0] ar, ai, br, bi, wr, wi,
                                          input bit scale);
        int t_re, t_im, xr, xi, yr, yi;
        t_re = clamp(cmul(s16(wr), s16(br)) - cmul(s16(wi), s16(bi)));
        t_im = clamp(cmul(s16(wr), s16(bi)) + cmul(s16(wi), s16(br)));
        xr = s16(ar) + t_re;
        xi = s16(ai) + t_im;
        yr = s16(ar) - t_re;
        yi = s16(ai) - t_im;
        if (scale) begin
            xr = xr >>> 1; xi = xi >>> 1; yr = yr >>> 1; yi = yi >>> 1;
        end else begin
            xr = clamp(xr); xi = clamp(xi); yr = clamp(yr); yi = clamp(yi);
        end
        return {16'(xr), 16'(xi), 16'(yr), 16'(yi)};
    endfunction

    task automatic scramble();
        a_re = 16'($urandom); a_im = 16'($urandom);
        b_re = 16'($urandom); b_im = 16'($urandom);
        w_re = 16'($urandom); w_im = 16'($urandom);
    endtask

    task automatic check_out(input string tag, input logic [63:0] e0, input logic [63:0] e1);
        check({tag, " s0 x_re"}, 32'(x0_re), 32'(e0[63:48]));
        check({tag, " s0 x_im"}, 32'(x0_im), 32'(e0[47:32]));
        check({tag, " s0 y_re"}, 32'(y0_re), 32'(e0[31:16]));
        check({tag, " s0 y_im"}, 32'(y0_im), 32'(e0[15:0]));
        check({tag, " s1 x_re"}, 32'(x1_re), 32'(e1[63:48]));
        check({tag, " s1 x_im"}, 32'(x1_im), 32'(e1[47:32]));
        check({tag, " s1 y_re"}, 32'(y1_re), 32'(e1[31:16]));
        check({tag, " s1 y_im"}, 32'(y1_im), 32'(e1[15:0]));
    endtask

    // One complete butterfly; out_ready is held low for `hold` cycles after out_valid.
    task automatic apply(input string tag, input logic [15:0] ar, ai, br, bi, wr, wi,
                         input int hold);
        logic [63:0] e0, e1;
        int lat;
        e0 = model(ar, ai, br, bi, wr, wi, 1'b0);
        e1 = model(ar, ai, br, bi, wr, wi, 1'b1);
        @(negedge clk);
        check({tag, " in_ready idle"}, 32'(in_ready0 & in_ready1), 32'd1);
        a_re = ar; a_im = ai; b_re = br; b_im = bi; w_re = wr; w_im = wi;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        scramble();
        lat = 1;
        while (!(out_valid0 && out_valid1) && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, " latency"}, 32'(lat), 32'd10);
        check({tag, " in_ready busy"}, 32'(in_ready0 | in_ready1), 32'd0);
        check_out(tag, e0, e1);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            scramble();
            @(posedge clk);
            #1;
            check({tag, " held out_valid"}, 32'(out_valid0 & out_valid1), 32'd1);
            check({tag, " held in_ready"}, 32'(in_ready0 | in_ready1), 32'd0);
            check_out({tag, " held"}, e0, e1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check({tag, " out_valid cleared"}, 32'(out_valid0 | out_valid1), 32'd0);
        check({tag, " in_ready restored"}, 32'(in_ready0 & in_ready1), 32'd1);
    endtask

    initial begin
        logic [63:0] exp_q[$];
        logic [15:0] set2 [6];
        int n_acc, n_out;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0;
        #12;
        check("reset in_ready", 32'(in_ready0 & in_ready1), 32'd1);
        check("reset out_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check("reset x/y", 32'(x0_re | x0_im | y0_re | y0_im | x1_re | y1_re), 32'd0);
        check("reset mul_en", 32'(dut0.mul_en | dut1.mul_en), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        apply("unit_w", 16'd320, 16'd0, 16'd80, 16'd0, 16'h4000, 16'h0000, 0);
        check("unit_w x_re lit", 32'(x0_re), 32'd400);
        check("unit_w y_re lit", 32'(y0_re), 32'd240);

        apply("minus_j", 16'd32, 16'd32, 16'd64, 16'd96, 16'h0000, 16'hC000, 0);
        check("minus_j x_re lit", 32'(x0_re), 32'd128);
        check("minus_j x_im lit", 32'(x0_im), 32'h0000FFE0);
        check("minus_j y_re lit", 32'(y0_re), 32'h0000FFC0);
        check("minus_j y_im lit", 32'(y0_im), 32'd96);

        apply("sat", 16'd32000, 16'd0, 16'd3200, 16'd0, 16'h4000, 16'h0000, 0);
        check("sat s0 x_re lit", 32'(x0_re), 32'h00007FFF);
        check("sat s0 y_re lit", 32'(y0_re), 32'd28800);
        check("sat s1 x_re lit", 32'(x1_re), 32'd17600);
        check("sat s1 y_re lit", 32'(y1_re), 32'd14400);

        apply("extreme", 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 16'h8000, 0);
        apply("backpressure", 16'd320, 16'd0, 16'd80, 16'd0, 16'h4000, 16'h0000, 5);

        // Reset while waiting on the second multiply.
        @(negedge clk);
        a_re = 16'd320; a_im = '0; b_re = 16'd80; b_im = '0; w_re = 16'h4000; w_im = '0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst out_valid", 32'(out_valid0 | out_valid1), 32'd0);
        check("midrst in_ready", 32'(in_ready0 & in_ready1), 32'd1);
        check("midrst mul_en", 32'(dut0.mul_en | dut1.mul_en), 32'd0);
        check("midrst x_re", 32'(x0_re | x1_re), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply("post_rst", 16'd320, 16'd0, 16'd80, 16'd0, 16'h4000, 16'h0000, 0);
        check("post_rst x_re lit", 32'(x0_re), 32'd400);

        // Back-to-back with in_valid held high across both operand sets.
        for (int i = 0; i < 6; i++) set2[i] = 16'($urandom);
        @(negedge clk);
        scramble();
        exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, 1'b0));
        exp_q.push_back(model(a_re, a_im, b_re, b_im, w_re, w_im, 1'b1));
        exp_q.push_back(model(set2[0], set2[1], set2[2], set2[3], set2[4], set2[5], 1'b0));
        exp_q.push_back(model(set2[0], set2[1], set2[2], set2[3], set2[4], set2[5], 1'b1));
        in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; n_out = 0;
        for (int cyc = 0; cyc < 200 && n_out < 2; cyc++) begin
            if (in_valid && in_ready0) n_acc++;
            if (out_valid0 && out_valid1 && out_ready) begin
                check_out((n_out == 0) ? "b2b first" : "b2b second",
                          exp_q[2 * n_out], exp_q[2 * n_out + 1]);
                n_out++;
            end
            @(posedge clk);
            #1;
            if (n_acc == 1) begin
                a_re = set2[0]; a_im = set2[1]; b_re = set2[2];
                b_im = set2[3]; w_re = set2[4]; w_im = set2[5];
            end else if (n_acc >= 2) begin
                in_valid = 1'b0;
            end
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b results seen", 32'(n_out), 32'd2);
        check("b2b accepts", 32'(n_acc), 32'd2);
        repeat (12) @(posedge clk);

        for (int i = 0; i < 24; i++)
            apply("random", 16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), int'($urandom_range(0, 2)));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
